cfg_readout_responder: RTL and testbench
========================================

Name: cfg_readout_responder

Overview:
- Read-side responder for the core's static configuration, exposing the user config fields as packed 32-bit words.
- Debug and software probes fetch words one at a time over a valid/ready request/response channel.
- A bulk "dump" mode streams every word in order, with a last marker on the final word.
- Sits beside the CSR/debug logic, fed by a flattened copy of the elaborated configuration.

Parameters:
- NrWords, 16, number of configuration words presented on cfg_words_i (>=1).
- AddrWidth, 8, width of the request word index; must satisfy 2**AddrWidth >= NrWords.
- DataWidth, 32, width of each configuration word.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- cfg_words_i  input  NrWords*DataWidth  flattened config words; word k occupies bits [k*DataWidth +: DataWidth]; quasi-static.
- req_valid_i  input  1  single-word read request valid.
- req_ready_o  output  1  request accepted when high together with req_valid_i.
- req_addr_i  input  AddrWidth  word index to read.
- dump_start_i  input  1  one-cycle pulse; starts a full streaming dump.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumer ready.
- rsp_data_o  output  DataWidth  response word.
- rsp_err_o  output  1  index out of range; data is 0.
- rsp_last_o  output  1  final word of a dump, or any single-word response.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state=IDLE, word counter=0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, rsp_last_o=0, busy_o=0.
  - Reset mid-dump or mid-response drops the transfer immediately; nothing resumes after reset.
- States: IDLE, SINGLE, DUMP.
- req_ready_o = (state==IDLE) && !dump_start_i. This is combinational; there is no request skid buffer.
- IDLE:
  - dump_start_i has priority over req_valid_i in the same cycle.
  - On dump_start_i: counter<=0; register word 0 into rsp_data_o; rsp_last_o <= (NrWords==1); go to DUMP.
  - Else on req_valid_i && req_ready_o:
    - If req_addr_i < NrWords: rsp_data_o<=word[req_addr_i], rsp_err_o<=0.
    - Else: rsp_data_o<=0, rsp_err_o<=1.
    - rsp_last_o<=1; go to SINGLE.
- Latency: response is valid in the cycle after the accepting edge (1 cycle).
- SINGLE:
  - rsp_valid_o=1; outputs are held stable while rsp_ready_i=0.
  - On rsp_ready_i: go to IDLE, rsp_valid_o=0 next cycle.
  - No new request is accepted in the same cycle, so the minimum single-read cadence is 2 cycles.
- DUMP:
  - rsp_valid_o=1; rsp_err_o=0 always.
  - On handshake with counter < NrWords-1: counter++, next word registered, rsp_last_o <= (counter+1 == NrWords-1). This gives 1 word per cycle at full throughput.
  - On handshake with counter == NrWords-1 (rsp_last_o=1): go to IDLE and clear the counter.
  - dump_start_i and req_valid_i are ignored while in DUMP; req_ready_o=0.
- Counter width: $clog2(NrWords)+1. It never wraps; the comparison is against NrWords-1.
- Valid/ready rules:
  - Once rsp_valid_o rises it stays high, with data, err and last stable, until the handshake.
  - rsp_valid_o does not depend combinationally on rsp_ready_i.
- cfg_words_i is sampled only when a word is loaded. Changes afterwards do not affect a pending response.
- busy_o = (state != IDLE).

Test Plan:
- Reset then single read: word 3 = 0xDEAD_BEEF; req addr=3 -> rsp_valid_o one cycle later, data=0xDEAD_BEEF, err=0, last=1; req_ready_o=0 until handshake; rsp_ready_i=1 -> IDLE.
- Out-of-range: NrWords=16, req addr=0x20 -> data=0, err=1, last=1.
- Dump at full rate: words k = 0x100+k, rsp_ready_i held 1 -> 16 consecutive beats 0x100..0x10F; last only on 0x10F; busy_o drops the cycle after.
- Backpressure: during a dump, drop rsp_ready_i for 5 cycles at word 7 -> 0x107 held stable with valid=1; stream resumes at 0x108 with no loss or duplication.
- Priority/collision: dump_start_i and req_valid_i high in the same IDLE cycle -> req_ready_o=0, dump starts; requests during DUMP are not accepted.
- Async reset mid-dump at word 5: rst_ni low -> rsp_valid_o=0 and busy_o=0 immediately; after release, a new dump begins again at word 0.

Source files
------------

// File: rtl/cfg_readout_responder.sv
// Read-side responder for the static configuration words.
// Serves single-word reads over a valid/ready channel and a streaming dump
// of all words with a last marker on the final beat.
module cfg_readout_responder #(
  parameter int unsigned NrWords   = 16,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrWords*DataWidth-1:0] cfg_words_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic                         dump_start_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DataWidth-1:0]         rsp_data_o,
  output logic                         rsp_err_o,
  output logic                         rsp_last_o,
  output logic                         busy_o
);

  // One extra bit so the counter never wraps, even for power-of-two NrWords.
  localparam int unsigned CntW = $clog2(NrWords) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NrWords - 1);
  localparam logic [AddrWidth:0] NrWordsExt = (AddrWidth + 1)'(NrWords);

  typedef enum logic [1:0] {StIdle, StSingle, StDump} state_e;

  state_e r_state, w_state_d;

  logic [CntW-1:0]      r_cnt, w_cnt_d, w_cnt_inc;
  logic [DataWidth-1:0] r_data, w_data_d;
  logic                 r_err, w_err_d;
  logic                 r_last, w_last_d;
  logic [DataWidth-1:0] w_addr_word, w_next_word;
  logic                 w_addr_ok;
  logic                 w_req_fire;
  logic                 w_rsp_fire;

  assign w_cnt_inc  = r_cnt + CntW'(1);
  assign w_addr_ok  = ({1'b0, req_addr_i} < NrWordsExt);
  assign w_req_fire = req_valid_i && req_ready_o;
  assign w_rsp_fire = rsp_valid_o && rsp_ready_i;

  // Word selected by the request address (zero when out of range).
  always_comb begin
    w_addr_word = '0;
    for (int unsigned k = 0; k < NrWords; k++) begin
      if (req_addr_i == AddrWidth'(k)) begin
        w_addr_word = cfg_words_i[k*DataWidth +: DataWidth];
      end
    end
  end

  // Word following the one currently presented in a dump.
  always_comb begin
    w_next_word = '0;
    for (int unsigned k = 0; k < NrWords; k++) begin
      if (w_cnt_inc == CntW'(k)) begin
        w_next_word = cfg_words_i[k*DataWidth +: DataWidth];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; dump_start_i wins over a same-cycle request.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (dump_start_i) begin
          w_state_d = StDump;
        end else if (w_req_fire) begin
          w_state_d = StSingle;
        end
      end
      StSingle: begin
        if (rsp_ready_i) begin
          w_state_d = StIdle;
        end
      end
      StDump: begin
        if (rsp_ready_i && (r_cnt == LastIdx)) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Response datapath next values; words are sampled only when loaded.
  always_comb begin
    w_cnt_d  = r_cnt;
    w_data_d = r_data;
    w_err_d  = r_err;
    w_last_d = r_last;
    unique case (r_state)
      StIdle: begin
        if (dump_start_i) begin
          w_cnt_d  = '0;
          w_data_d = cfg_words_i[DataWidth-1:0];
          w_err_d  = 1'b0;
          w_last_d = (NrWords == 1);
        end else if (w_req_fire) begin
          w_data_d = w_addr_ok ? w_addr_word : '0;
          w_err_d  = !w_addr_ok;
          w_last_d = 1'b1;
        end
      end
      StSingle: ;
      StDump: begin
        if (w_rsp_fire) begin
          if (r_cnt == LastIdx) begin
            w_cnt_d = '0;
          end else begin
            w_cnt_d  = w_cnt_inc;
            w_data_d = w_next_word;
            w_last_d = (w_cnt_inc == LastIdx);
          end
        end
      end
      default: ;
    endcase
  end

  // Response datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_data <= w_data_d;
      r_err  <= w_err_d;
      r_last <= w_last_d;
    end
  end

  // Outputs: valid comes from state only, never from rsp_ready_i.
  always_comb begin
    req_ready_o = (r_state == StIdle) && !dump_start_i;
    rsp_valid_o = (r_state != StIdle);
    busy_o      = (r_state != StIdle);
    rsp_data_o  = r_data;
    rsp_err_o   = r_err;
    rsp_last_o  = r_last;
  end

endmodule

// File: tb/tb_cfg_readout_responder.sv
// Self-checking bench for cfg_readout_responder: single reads, out-of-range
// reads, full-rate and stalled dumps, start/request collision, async reset.
module tb_cfg_readout_responder;

  localparam int N  = 16;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [N*DW-1:0] cfg_words;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          dump_start;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_last;
  logic          busy;

  logic [DW-1:0] words [N];
  int vectors;
  int miscompares;

  cfg_readout_responder #(
    .NrWords  (N),
    .AddrWidth(AW),
    .DataWidth(DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_words_i (cfg_words),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .dump_start_i(dump_start),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_words();
    for (int k = 0; k < N; k++) cfg_words[k*DW +: DW] = words[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; dump_start = 1'b0; rsp_ready = 1'b0;
    #3;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== '0) begin miscompares++;
      $display("FAIL reset_data got %h want 0", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++;
      $display("FAIL reset_err got %b want 0", rsp_err); end
    vectors++; if (rsp_last !== 1'b0) begin miscompares++;
      $display("FAIL reset_last got %b want 0", rsp_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_req_ready got %b want 1", req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single read; holds rsp_ready low for 'stall' cycles and perturbs the
  // source word meanwhile to show the loaded response does not change.
  task automatic test_single(input logic [AW-1:0] addr, input int stall);
    logic [DW-1:0] exp_d;
    logic          exp_e;
    exp_e = (int'(addr) >= N);
    exp_d = exp_e ? '0 : words[addr];
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL single_accept_ready got %b want 1", req_ready); end
    @(negedge clk);
    req_addr = ~addr;  // further request must not be taken while busy
    if (!exp_e) cfg_words[int'(addr)*DW +: DW] = ~words[addr];
    for (int c = 0; c <= stall; c++) begin
      rsp_ready = (c == stall);
      #1;
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++;
        $display("FAIL single_valid addr=%0d got %b want 1", addr, rsp_valid); end
      vectors++; if (rsp_data !== exp_d) begin miscompares++;
        $display("FAIL single_data addr=%0d got %h want %h", addr, rsp_data, exp_d); end
      vectors++; if (rsp_err !== exp_e) begin miscompares++;
        $display("FAIL single_err addr=%0d got %b want %b", addr, rsp_err, exp_e); end
      vectors++; if (rsp_last !== 1'b1) begin miscompares++;
        $display("FAIL single_last addr=%0d got %b want 1", addr, rsp_last); end
      vectors++; if (busy !== 1'b1) begin miscompares++;
        $display("FAIL single_busy addr=%0d got %b want 1", addr, busy); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++;
        $display("FAIL single_req_ready addr=%0d got %b want 0", addr, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    load_words();
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++;
      $display("FAIL single_done_valid got %b want 0", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL single_done_busy got %b want 0", busy); end
  endtask

  // Dump of all words. stall_at/stall_len: hold ready low at that word;
  // rnd: random ready and random ignored start/requests; collide: raise
  // req_valid with dump_start; reset_at: assert reset while showing that word.
  task automatic test_dump(input int stall_at, input int stall_len, input bit rnd,
                           input bit collide, input int reset_at);
    int  k, stalled, budget;
    bit  aborted;
    logic rdy;
    @(negedge clk);
    dump_start = 1'b1; req_valid = collide; req_addr = AW'($urandom_range(0, N-1));
    #1;
    vectors++; if (req_ready !== 1'b0) begin miscompares++;
      $display("FAIL dump_start_req_ready got %b want 0", req_ready); end
    @(negedge clk);
    dump_start = 1'b0; req_valid = 1'b0;
    k = 0; stalled = 0; budget = 0; aborted = 1'b0;
    while (k < N && budget < 200) begin
      budget++;
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++;
          $display("FAIL async_reset_valid got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++;
          $display("FAIL async_reset_busy got %b want 0", busy); end
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else if (k == stall_at && stalled < stall_len) begin rdy = 1'b0; stalled++; end
      else rdy = 1'b1;
      rsp_ready  = rdy;
      dump_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      req_valid  = rnd ? 1'($urandom_range(0, 1)) : collide;
      #1;
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++;
        $display("FAIL dump_valid k=%0d got %b want 1", k, rsp_valid); end
      vectors++; if (rsp_data !== words[k]) begin miscompares++;
        $display("FAIL dump_data k=%0d got %h want %h", k, rsp_data, words[k]); end
      vectors++; if (rsp_last !== (k == N-1)) begin miscompares++;
        $display("FAIL dump_last k=%0d got %b want %b", k, rsp_last, (k == N-1)); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++;
        $display("FAIL dump_err k=%0d got %b want 0", k, rsp_err); end
      vectors++; if (busy !== 1'b1) begin miscompares++;
        $display("FAIL dump_busy k=%0d got %b want 1", k, busy); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++;
        $display("FAIL dump_req_ready k=%0d got %b want 0", k, req_ready); end
      if (rdy) k++;
      @(negedge clk);
    end
    if (!aborted && k < N) begin
      vectors++; miscompares++;
      $display("FAIL dump_timeout got %0d beats want %0d", k, N);
    end
    dump_start = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    if (!aborted) begin
      #1;
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++;
        $display("FAIL dump_end_valid got %b want 0", rsp_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++;
        $display("FAIL dump_end_busy got %b want 0", busy); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    for (int k = 0; k < N; k++) words[k] = $urandom;
    words[3] = 32'hDEAD_BEEF;
    load_words();
    test_reset();

    // Single reads: the documented word, random in-range, out-of-range.
    test_single(8'd3, 0);
    test_single(8'd3, 3);
    for (int i = 0; i < 8; i++) test_single(AW'($urandom_range(0, N-1)), $urandom_range(0, 3));
    test_single(8'h20, 0);
    test_single(8'd16, 2);
    test_single(8'hFF, 1);
    for (int i = 0; i < 4; i++) test_single(AW'($urandom_range(N, 255)), $urandom_range(0, 2));

    // Dumps with the documented 0x100+k pattern.
    for (int k = 0; k < N; k++) words[k] = 32'h100 + k;
    load_words();
    test_dump(-1, 0, 1'b0, 1'b0, -1);   // full rate
    test_dump(7, 5, 1'b0, 1'b0, -1);    // backpressure at word 7
    test_dump(-1, 0, 1'b0, 1'b1, -1);   // start/request collision
    test_dump(-1, 0, 1'b0, 1'b0, 5);    // async reset at word 5
    test_dump(-1, 0, 1'b0, 1'b0, -1);   // restarts at word 0
    test_single(8'd15, 0);

    // Random words, random backpressure and ignored controls.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) words[k] = $urandom;
      load_words();
      test_dump(-1, 0, 1'b1, 1'b0, -1);
      test_single(AW'($urandom_range(0, 255)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
